// File: rtl/gray_monitor.sv
// gray_monitor: follows a 3-bit reflected Gray counter. It keeps a registered
// binary copy of the count, pulses Step on each legal +1 advance, and counts
// 7->0 wraps with a saturating lap counter. It checks the upstream sticky
// overflow flag against the observed lap history. The first illegal
// observation is latched as a sticky error until Clear.
module gray_monitor #(
   parameter int LAP_W = 8
) (
   input  logic             Clk,
   input  logic             Reset,
   input  logic             Sample,
   input  logic [2:0]       GrayIn,
   input  logic             OvIn,
   input  logic             Clear,
   output logic [2:0]       Bin,
   output logic             Step,
   output logic [LAP_W-1:0] Laps,
   output logic             LapSat,
   output logic             Err,
   output logic [1:0]       ErrCode,
   output logic [1:0]       State
);

   typedef enum logic [1:0] {
      S_IDLE  = 2'b00,
      S_TRACK = 2'b01,
      S_ERROR = 2'b10
   } state_t;

   typedef enum logic [1:0] {
      E_NONE = 2'b00,
      E_BACK = 2'b01,
      E_JUMP = 2'b10,
      E_OVF  = 2'b11
   } err_t;

   state_t           r_state;
   logic [2:0]       r_bin;
   logic             r_step;
   logic [LAP_W-1:0] r_laps;
   logic             r_lap_sat;
   logic             r_err;
   err_t             r_err_code;

   logic [2:0]       w_new_bin;
   logic [2:0]       w_bin_inc;
   logic [2:0]       w_bin_dec;
   logic             w_wrap;
   logic             w_laps_full;
   logic             w_ovf_err;

   // Each binary bit is the XOR of the Gray bits at and above its position.
   assign w_new_bin   = {GrayIn[2],
                         GrayIn[2] ^ GrayIn[1],
                         GrayIn[2] ^ GrayIn[1] ^ GrayIn[0]};
   // The 3-bit arithmetic wraps on its own, giving +1 and -1 modulo 8.
   assign w_bin_inc   = r_bin + 3'd1;
   assign w_bin_dec   = r_bin - 3'd1;
   assign w_wrap      = (r_bin == 3'd7) && (w_new_bin == 3'd0);
   assign w_laps_full = &r_laps;
   // The overflow flag must rise exactly at the first wrap.
   // A wrap without it, or the flag before any lap was seen, is a mismatch.
   // Laps saturates and never returns to zero, so "Laps == 0" means no lap yet.
   assign w_ovf_err   = (w_wrap && !OvIn) || (!w_wrap && OvIn && (r_laps == '0));

   // Monitor FSM with every output registered. Priority is Reset, then Clear, then Sample.
   always_ff @(posedge Clk) begin
      // NOTE: non-blocking assignments only, so every branch below sees the pre-edge state.
      if (Reset) begin
         r_state    <= S_IDLE;
         r_bin      <= '0;
         r_step     <= 1'b0;
         r_laps     <= '0;
         r_lap_sat  <= 1'b0;
         r_err      <= 1'b0;
         r_err_code <= E_NONE;
      end else begin
         r_step <= 1'b0;
         if (Clear) begin
            // Lap history survives a Clear. Only the error is dropped and tracking re-armed.
            r_state    <= S_IDLE;
            r_err      <= 1'b0;
            r_err_code <= E_NONE;
         end else if (Sample) begin
            case (r_state)
               S_IDLE: begin
                  // The first code after arming is trusted as the starting point.
                  r_bin   <= w_new_bin;
                  r_state <= S_TRACK;
               end
               S_TRACK: begin
                  // The overflow check runs first.
                  // A wrap sampled with OvIn low reports 11 and does not count a lap.
                  if (w_ovf_err) begin
                     r_err      <= 1'b1;
                     r_err_code <= E_OVF;
                     r_state    <= S_ERROR;
                  end else if (w_new_bin == w_bin_inc) begin
                     r_bin  <= w_new_bin;
                     r_step <= 1'b1;
                     if (w_wrap) begin
                        if (w_laps_full) begin
                           r_lap_sat <= 1'b1;
                        end else begin
                           r_laps <= r_laps + LAP_W'(1);
                        end
                     end
                  end else if (w_new_bin == w_bin_dec) begin
                     r_err      <= 1'b1;
                     r_err_code <= E_BACK;
                     r_state    <= S_ERROR;
                  end else if (w_new_bin != r_bin) begin
                     r_err      <= 1'b1;
                     r_err_code <= E_JUMP;
                     r_state    <= S_ERROR;
                  end
               end
               S_ERROR: begin
                  // Samples are ignored until Clear or Reset.
               end
               default: begin
                  r_state <= S_IDLE;
               end
            endcase
         end
      end
   end

   assign Bin     = r_bin;
   assign Step    = r_step;
   assign Laps    = r_laps;
   assign LapSat  = r_lap_sat;
   assign Err     = r_err;
   assign ErrCode = r_err_code;
   assign State   = r_state;

endmodule

// File: doc/gray_monitor.md
GRAY_MONITOR -- requirements
Module: gray_monitor

Interface
REQ-001 The block SHALL have parameter LAP_W, default 8, giving the width of the wrap (lap) counter.
REQ-002 The block SHALL have port Clk, input, 1, rising-edge clock.
REQ-003 The block SHALL have port Reset, input, 1, reset: synchronous, active-high; clock Clk.
REQ-004 The block SHALL have port Sample, input, 1, high: sample GrayIn/OvIn this cycle.
REQ-005 The block SHALL have port GrayIn, input, 3, 3-bit reflected Gray code from the upstream counter.
REQ-006 The block SHALL have port OvIn, input, 1, sticky overflow flag from the upstream counter.
REQ-007 The block SHALL have port Clear, input, 1, high: clear the error and re-arm tracking.
REQ-008 The block SHALL have port Bin, output, 3, registered binary equivalent of the last accepted code.
REQ-009 The block SHALL have port Step, output, 1, one-cycle pulse per legal +1 advance.
REQ-010 The block SHALL have port Laps, output, LAP_W, count of observed 7->0 wraps.
REQ-011 The block SHALL have port LapSat, output, 1, sticky: Laps saturated.
REQ-012 The block SHALL have port Err, output, 1, sticky error flag.
REQ-013 The block SHALL have port ErrCode, output, 2, error cause: 00 none, 01 backward step, 10 multi-bit jump, 11 overflow mismatch.
REQ-014 The block SHALL have port State, output, 2, FSM state: 00 IDLE, 01 TRACK, 10 ERROR.

Function
REQ-015 Gray-to-binary conversion SHALL be b2=g2, b1=g2^g1, b0=g2^g1^g0.
REQ-016 All outputs SHALL be registered and update only on the rising edge of Clk.
REQ-017 In IDLE with Sample=1, the block SHALL load Bin from GrayIn, go to TRACK, and do no check, Step, or Laps update.
REQ-018 In TRACK with Sample=0, the block SHALL hold all state, with Step=0.
REQ-019 In TRACK with Sample=1 and an unchanged code, the block SHALL hold, with Step=0; stalls are legal.
REQ-020 In TRACK with Sample=1 and new binary = (Bin+1) mod 8, the block SHALL update Bin and pulse Step=1 for exactly that cycle.
REQ-021 A legal step from Bin=7 to Bin=0 SHALL count as a wrap: Laps increments by 1.
REQ-022 When Laps is all-ones, a wrap SHALL leave Laps unchanged and set LapSat=1 (sticky).
REQ-023 A wrap sampled with OvIn=0 SHALL be an error with ErrCode 11.
REQ-024 In TRACK, OvIn=1 sampled while Laps=0 and no wrap in the same sample SHALL be an error with ErrCode 11.
REQ-025 In TRACK, new binary = (Bin-1) mod 8 SHALL be an error with ErrCode 01.
REQ-026 In TRACK, any other change (more than one Gray bit differs) SHALL be an error with ErrCode 10.
REQ-027 On any error, the block SHALL set Err=1, latch ErrCode, go to ERROR, leave Bin and Laps unchanged, and keep Step=0.
REQ-028 In ERROR, the block SHALL ignore Sample; Err, ErrCode, Bin and Laps hold.
REQ-029 Clear=1 in any state SHALL set Err=0 and ErrCode=00 and go to IDLE, leaving Laps and LapSat unchanged.
REQ-030 Clear SHALL take priority over Sample in the same cycle; the sample is discarded.
REQ-031 Only the first detected cause SHALL be latched; a wrap with OvIn=0 reports 11 and does not increment Laps.

Reset
REQ-032 Reset SHALL have priority over Clear and Sample.
REQ-033 Reset=1 SHALL set State=IDLE, Bin=000, Step=0, Laps=0, LapSat=0, Err=0, ErrCode=00 on the next Clk edge, including mid-run and in ERROR.
REQ-034 After Reset is released, the first Sample SHALL be treated as in IDLE (REQ-017).

Verification
REQ-035 The bench SHALL cover: Reset, then Sample every cycle with GrayIn 000,001,011,010,110,111,101,100 -> Bin 0..7, Step=1 on the seven advances, Err=0, Laps=0.
REQ-036 The bench SHALL cover: continue to GrayIn=000 with OvIn=1 -> Bin=0, Step=1, Laps=1; repeat one further full cycle -> Laps=2, no error.
REQ-037 The bench SHALL cover: in TRACK at GrayIn=011 (Bin=2), sample 001 -> Err=1, ErrCode=01, State=10, Bin stays 2; then Clear -> State=00, Err=0.
REQ-038 The bench SHALL cover: at Bin=1 (001), sample 110 -> ErrCode=10; further Samples ignored until Clear.
REQ-039 The bench SHALL cover: wrap 100->000 with OvIn=0 -> ErrCode=11, Laps unchanged; and OvIn=1 sampled at Laps=0 without a wrap -> ErrCode=11.
REQ-040 The bench SHALL cover: LAP_W=2, drive 4 wraps -> Laps=3, LapSat=1; then assert Reset mid-sequence together with Clear and Sample -> all outputs at reset values next cycle.
